// File: rtl/hpi_pkg.sv
// Shared types and constants for the HPI transaction sequencer.
package hpi_pkg;

  // Width of the single down-counter that times every FSM state.
  localparam int CNT_W = 4;

  // HPI register-select encodings presented on hpi_addr.
  localparam logic [1:0] HPI_DATA    = 2'b00;
  localparam logic [1:0] HPI_MAILBOX = 2'b01;
  localparam logic [1:0] HPI_ADDR    = 2'b10;
  localparam logic [1:0] HPI_STATUS  = 2'b11;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/hpi_rr_arb.sv
// Two-way round-robin arbiter. The pointer only moves when both ports
// compete, so a lone requester never steals the other port's next turn.
module hpi_rr_arb (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant_idx,
  output logic       grant_valid
);

  logic ptr_q;

  // Pick the favoured port on contention, otherwise the only requester.
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) grant_idx = ptr_q;
    else              grant_idx = req[1];
  end

  // Hand priority to the loser once a contended grant is taken.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                          ptr_q <= 1'b0;
    else if (grant_en && req == 2'b11)  ptr_q <= ~grant_idx;
  end

endmodule

// File: rtl/hpi_txn_ctrl.sv
// HPI transaction sequencer: arbitrates two requesters and produces the
// registered CS/RD/WR strobe sequence towards the HPI I/O interface.
module hpi_txn_ctrl
  import hpi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 2,
  parameter int IDLE_CYC   = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [1:0]  addr0,
  input  logic [1:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_dout,
  input  logic [15:0] hpi_din,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic        hpi_cs_n
);

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LD   = CNT_W'(IDLE_CYC - 1);
  // Second HOLD cycle: the pin-side read data has just arrived on hpi_din.
  localparam logic [CNT_W-1:0] HOLD_CAP  = CNT_W'(HOLD_CYC - 2);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d;    // granted port
  logic              dir_q, dir_d;    // 1 = write
  logic [1:0]        addr_d;
  logic [15:0]       dout_d, rdata_d;
  logic              cs_n_d, r_n_d, w_n_d, busy_d;
  logic [1:0]        ack_d;
  logic              grant_en, arb_idx, arb_valid;

  hpi_rr_arb u_arb (
    .Clk         (Clk),
    .Reset       (Reset),
    .req         (req),
    .grant_en    (grant_en),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  // Next-state and next-output decode; every pin is registered below.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    addr_d   = hpi_addr;
    dout_d   = hpi_dout;
    rdata_d  = rdata;
    cs_n_d   = hpi_cs_n;
    r_n_d    = hpi_r_n;
    w_n_d    = hpi_w_n;
    ack_d    = 2'b00;
    grant_en = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_en = 1'b1;
          sel_d    = arb_idx;
          dir_d    = we[arb_idx];
          addr_d   = arb_idx ? addr1  : addr0;
          dout_d   = arb_idx ? wdata1 : wdata0;
          cs_n_d   = 1'b0;
          state_d  = ST_SETUP;
          cnt_d    = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          r_n_d   = dir_q;
          w_n_d   = ~dir_q;
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          r_n_d   = 1'b1;
          w_n_d   = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (!dir_q && cnt_q == HOLD_CAP) rdata_d = hpi_din;
        if (cnt_q == '0) begin
          cs_n_d        = 1'b1;
          ack_d[sel_q]  = 1'b1;
          state_d       = ST_GAP;
          cnt_d         = IDLE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counter and all outputs; reset parks the bus with strobes high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      dir_q    <= 1'b0;
      hpi_addr <= '0;
      hpi_dout <= '0;
      rdata    <= '0;
      hpi_cs_n <= 1'b1;
      hpi_r_n  <= 1'b1;
      hpi_w_n  <= 1'b1;
      ack      <= 2'b00;
      busy     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      dir_q    <= dir_d;
      hpi_addr <= addr_d;
      hpi_dout <= dout_d;
      rdata    <= rdata_d;
      hpi_cs_n <= cs_n_d;
      hpi_r_n  <= r_n_d;
      hpi_w_n  <= w_n_d;
      ack      <= ack_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: doc/hpi_txn_ctrl.md
Name: hpi_txn_ctrl

Overview:
- Transaction sequencer for the CY7C67200 HPI port. Sits between two requesters and the software-side pins of the HPI I/O interface.
  - Port 0: NIOS software bridge.
  - Port 1: hardware USB-keyboard poller.
- Arbitrates between the two requesters round-robin.
- Generates the timed, active-low CS/RD/WR strobe sequence for each transfer.
- Captures read data, allowing for the I/O interface's one-cycle output and input registers.
- Returns a one-cycle acknowledge carrying the read data.

Parameters:
- SETUP_CYC, 1, cycles CS low with address/data valid before the strobe; range 1..15.
- STROBE_CYC, 2, cycles the RD_N or WR_N request is held low; range 1..15.
- HOLD_CYC, 2, cycles CS low after the strobe is released; range 2..15 (read capture needs 2).
- IDLE_CYC, 1, minimum cycles CS high between transactions; range 1..15.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- req  in  2  per-port request; must be held until the matching ack bit
- we  in  2  per-port direction: 1 = write, 0 = read
- addr0, addr1  in  2 each  HPI register select (00 DATA, 01 MAILBOX, 10 ADDR, 11 STATUS)
- wdata0, wdata1  in  16 each  write data
- ack  out  2  one-cycle completion pulse per port
- rdata  out  16  read data; valid in the ack cycle, held until the next capture
- busy  out  1  high in any state other than IDLE
- hpi_addr  out  2  to the I/O interface address input
- hpi_dout  out  16  to the I/O interface write-data input
- hpi_din  in  16  from the I/O interface read-data output (already registered there)
- hpi_r_n, hpi_w_n, hpi_cs_n  out  1 each  to the I/O interface strobe inputs, active low

Behaviour:
- Reset values:
  - hpi_cs_n = hpi_r_n = hpi_w_n = 1.
  - hpi_addr = 0, hpi_dout = 0, rdata = 0, ack = 0, busy = 0.
  - Round-robin pointer favours port 0 first; state = IDLE; counter = 0.
- All outputs are registered. No combinational path from req to the hpi_* outputs.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP. A single 4-bit down-counter times every state.
- IDLE:
  - If any req bit is set, grant one port.
  - Only one port requesting: grant that port.
  - Both requesting: grant the port the pointer favours, then move the pointer to the other port.
  - On grant, latch the port's addr/we/wdata into hpi_addr/hpi_dout and an internal dir flag.
  - Drive hpi_cs_n = 0 and go to SETUP with counter = SETUP_CYC-1.
- SETUP: counts to 0, then drives hpi_r_n = 0 (read) or hpi_w_n = 0 (write) and enters STROBE with counter = STROBE_CYC-1.
- STROBE: counts to 0, then releases the strobe to 1 and enters HOLD with counter = HOLD_CYC-1.
- HOLD:
  - On HOLD cycle index 1 (second HOLD cycle), read transactions latch hpi_din into rdata.
    - The pin-side RD_N is low one cycle later than hpi_r_n.
    - The last pin-side strobe cycle is therefore HOLD index 0; its data appears on hpi_din at HOLD index 1.
  - When the count reaches 0: drive hpi_cs_n = 1, pulse ack[granted] for one cycle, enter GAP with counter = IDLE_CYC-1.
- GAP: counts to 0, then returns to IDLE. The requester samples ack and drops req during GAP, so it is not re-granted.
- Strobe exclusivity:
  - hpi_r_n and hpi_w_n are never both 0.
  - Each strobe is 0 only while hpi_cs_n = 0.
- Bus turnaround: the I/O interface drives the pins whenever its write strobe is low. hpi_w_n therefore stays 1 for every read and outside STROBE.
- Stability: hpi_addr and hpi_dout are stable from SETUP entry until GAP exit.
- Transaction length: SETUP_CYC + STROBE_CYC + HOLD_CYC cycles of CS low; the ack pulse falls in the cycle CS goes high.
- A req drop before ack is a protocol violation. The transaction still completes and ack still pulses.
- Asynchronous Reset mid-transaction: strobes and CS go to 1 immediately, no ack is issued, pointer returns to port 0.

Decomposition:
- Package hpi_pkg:
  - State enum typedef.
  - HPI register-select constants: HPI_DATA, HPI_MAILBOX, HPI_ADDR, HPI_STATUS.
  - Counter width localparam (4).
- Sub-module hpi_rr_arb: 2-way round-robin arbiter with a grant-enable input and a registered pointer.
- FSM and counter stay in the top module.

Test Plan:
- Port 0 write, addr=10, wdata=0x1234, defaults -> hpi_cs_n low 5 cycles; hpi_w_n low exactly 2 cycles starting SETUP+1; hpi_r_n stays 1; ack[0] one pulse in the CS-rise cycle.
- Port 1 read, addr=00, pin model returns 0xBEEF while pin RD_N is low -> rdata = 0xBEEF with ack[1]; hpi_w_n stays 1 throughout.
- Both ports requesting continuously, 4 transactions -> grant order 0,1,0,1; at least IDLE_CYC CS-high cycles between transactions.
- Reset asserted in the second STROBE cycle -> same-cycle strobes and CS = 1, ack = 0; after release, a port-1-only request is granted normally.
- SETUP_CYC=3, STROBE_CYC=5, HOLD_CYC=2, IDLE_CYC=4 read of 0x00A5 -> CS low 10 cycles, RD low 5 cycles, rdata = 0x00A5, 4-cycle gap.
- Assertions throughout: never r_n = w_n = 0; no strobe while cs_n = 1; hpi_addr/hpi_dout stable while cs_n = 0.
